fdivsqrt_seq: RTL

- Sequencing controller and requester arbiter for the shared iterative divide/square-root datapath.
- Accepts floating-point fdiv/fsqrt requests from the FPU and integer div/rem requests from the IEU (the IDIV_ON_FPU configuration).
- Grants one requester at a time, pulses the datapath load, then enables iterations for a bounded cycle count.
- Signals completion, holds the result while the memory stage is stalled, and aborts on flush.

---
 rtl/fdivsqrt_seq_pkg.sv | 14 +
 rtl/fdivsqrt_arb.sv | 14 +
 rtl/fdivsqrt_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/fdivsqrt_seq_pkg.sv
// Shared types for the divide/square-root sequencer: FSM state encoding and
// default sizing of the iteration counter.
package fdivsqrt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fdivsqrt_state_t;

    localparam int DURLEN_DEFAULT = 5;
    localparam int FPDUR_DEFAULT  = 15;

endpackage

// File: rtl/fdivsqrt_arb.sv
// Two-requester fixed-priority arbiter: FP beats integer, grants are one-hot
// and only issued while the enable is high.
module fdivsqrt_arb (
    input  logic i_en,
    input  logic i_req_fp,
    input  logic i_req_int,
    output logic o_grant_fp,
    output logic o_grant_int
);

    assign o_grant_fp  = i_en & i_req_fp;
    assign o_grant_int = i_en & ~i_req_fp & i_req_int;

endmodule

// File: rtl/fdivsqrt_seq.sv
// Sequencer for the shared iterative div/sqrt datapath: arbitrates FP and
// integer requesters, loads the datapath, counts iterations, holds DONE on stall.
module fdivsqrt_seq
    import fdivsqrt_seq_pkg::*;
#(
    parameter int DURLEN = DURLEN_DEFAULT,
    parameter int FPDUR  = FPDUR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FDivReqE,
    input  logic [DURLEN-1:0] FCyclesE,
    input  logic              IDivReqE,
    input  logic [DURLEN-1:0] ICyclesE,
    input  logic              SpecialCaseE,
    input  logic              StallM,
    input  logic              FlushE,
    output logic              GrantFp,
    output logic              GrantInt,
    output logic              LoadE,
    output logic              IterEn,
    output logic              BusyE,
    output logic              OwnerInt,
    output logic              DoneM
);

    localparam logic [DURLEN-1:0] FPDUR_V = DURLEN'(FPDUR);

    fdivsqrt_state_t   r_state;
    fdivsqrt_state_t   w_state_next;
    logic [DURLEN-1:0] r_cnt;
    logic [DURLEN-1:0] w_cnt_next;
    logic              r_owner_int;
    logic              w_owner_next;
    logic              w_arb_en;
    logic              w_grant_fp;
    logic              w_grant_int;
    logic              w_grant;
    logic [DURLEN-1:0] w_sel_cycles;
    logic [DURLEN-1:0] w_load_cnt;

    // Reset gates the enable so no grant leaks out while reset is held.
    assign w_arb_en = (r_state == IDLE) & ~FlushE & ~reset;

    fdivsqrt_arb u_arb (
        .i_en        (w_arb_en),
        .i_req_fp    (FDivReqE),
        .i_req_int   (IDivReqE),
        .o_grant_fp  (w_grant_fp),
        .o_grant_int (w_grant_int)
    );

    assign w_grant      = w_grant_fp | w_grant_int;
    assign w_sel_cycles = w_grant_fp ? FCyclesE : ICyclesE;
    assign w_load_cnt   = (w_sel_cycles > FPDUR_V) ? FPDUR_V : w_sel_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_owner_int <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_owner_int <= w_owner_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_owner_next = r_owner_int;
        if (FlushE) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        w_cnt_next   = w_load_cnt;
                        w_owner_next = w_grant_int;
                        w_state_next = SpecialCaseE ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    // Cnt==0 still iterates this cycle, giving N+1 iterations.
                    if (r_cnt == '0) w_state_next = DONE;
                    else             w_cnt_next   = r_cnt - DURLEN'(1);
                end
                DONE: begin
                    if (!StallM) w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign GrantFp  = w_grant_fp;
    assign GrantInt = w_grant_int;
    assign LoadE    = w_grant;
    assign IterEn   = (r_state == BUSY);
    assign BusyE    = (r_state != IDLE);
    assign OwnerInt = r_owner_int;
    assign DoneM    = (r_state == DONE) & ~FlushE;

endmodule
